// File: rtl/iter_div_pkg.sv
// Shared state encodings and sizing constants for the iterative divider.
package iter_div_pkg;

  localparam int unsigned DIV_WIDTH   = 32;
  localparam int unsigned DIV_LATENCY = DIV_WIDTH + 1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/iter_div_step.sv
// One radix-2 restoring division step: shift {r,q} left and try subtracting the divisor.
module iter_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // r < d keeps the trial inside WIDTH+1 bits, so its top bit is the sign
  assign shifted = {r, q[WIDTH-1]};
  assign trial   = shifted - {1'b0, d};

  always_comb begin
    r_next = shifted[WIDTH-1:0];
    q_next = {q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      r_next = trial[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/iter_div.sv
// Iterative restoring divider (DIV/DIVU) with one-cycle div_complete pulse.
// Optional early-out for trivial quotients when DIV_EARLY_OUT_EN is defined.
module iter_div
  import iter_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div,
  input  logic             div_signed,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             div_complete,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_mag;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             start_q_neg;
  logic             start_r_neg;
  logic [WIDTH-1:0] step_r;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Operand magnitudes; -0x80..0 wraps to itself and is read as unsigned
  assign a_mag       = (div_signed && dividend[WIDTH-1]) ? WIDTH'(-dividend) : dividend;
  assign b_mag       = (div_signed && divisor[WIDTH-1])  ? WIDTH'(-divisor)  : divisor;
  assign start_q_neg = div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
  assign start_r_neg = div_signed & dividend[WIDTH-1];

  iter_div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .q      (q_q),
    .d      (d_mag),
    .r_next (step_r),
    .q_next (step_q)
  );

  // Sign fix applied to the final step so results land in the DONE cycle
  assign q_fix = q_neg ? WIDTH'(-step_q) : step_q;
  assign r_fix = r_neg ? WIDTH'(-step_r) : step_r;

`ifdef DIV_EARLY_OUT_EN
  logic             early;
  logic [WIDTH-1:0] early_q;

  assign early   = (b_mag == '0) || (a_mag < b_mag);
  assign early_q = (b_mag == '0) ? '1 : '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= DIV_IDLE;
      count        <= '0;
      busy         <= 1'b0;
      div_complete <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      r_q          <= '0;
      q_q          <= '0;
      d_mag        <= '0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
    end else begin
      div_complete <= 1'b0;
      unique case (state)
        DIV_IDLE: begin
          if (div && !cancel) begin
            r_q   <= '0;
            q_q   <= a_mag;
            d_mag <= b_mag;
            q_neg <= start_q_neg;
            r_neg <= start_r_neg;
            count <= '0;
            busy  <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            if (early) begin
              state        <= DIV_DONE;
              div_complete <= 1'b1;
              quotient     <= start_q_neg ? WIDTH'(-early_q) : early_q;
              remainder    <= dividend;
            end else begin
              state <= DIV_CALC;
            end
`else
            state <= DIV_CALC;
`endif
          end
        end
        DIV_CALC: begin
          if (cancel) begin
            state <= DIV_IDLE;
            busy  <= 1'b0;
          end else begin
            r_q   <= step_r;
            q_q   <= step_q;
            count <= count + CW'(1);
            if (count == CW'(WIDTH - 1)) begin
              state        <= DIV_DONE;
              div_complete <= 1'b1;
              quotient     <= q_fix;
              remainder    <= r_fix;
            end
          end
        end
        DIV_DONE: begin
          state <= DIV_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= DIV_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
